// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between NUM_MASTERS Wishbone masters, the round-robin arbiter and one shared slave.
// "slave" modport is the arbiter's view; "master" is the view of everything around it (masters plus slave).
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS*32-1:0] m_addr;
  logic [NUM_MASTERS*32-1:0] m_data_w;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [NUM_MASTERS-1:0]    m_stb;
  logic [NUM_MASTERS-1:0]    m_cyc;
  logic [31:0]               m_data_r;
  logic [NUM_MASTERS-1:0]    m_ack;
  logic [NUM_MASTERS-1:0]    m_stall;

  logic [31:0] s_addr;
  logic [31:0] s_data_w;
  logic        s_we;
  logic        s_stb;
  logic        s_cyc;
  logic [31:0] s_data_r;
  logic        s_ack;
  logic        s_stall;

  modport master (
    output m_addr, m_data_w, m_we, m_stb, m_cyc, s_data_r, s_ack, s_stall,
    input  m_data_r, m_ack, m_stall, s_addr, s_data_w, s_we, s_stb, s_cyc
  );

  modport slave (
    input  m_addr, m_data_w, m_we, m_stb, m_cyc, s_data_r, s_ack, s_stall,
    output m_data_r, m_ack, m_stall, s_addr, s_data_w, s_we, s_stb, s_cyc
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among NUM_MASTERS masters.
// state | meaning
// IDLE  | no owner, waiting for any m_cyc
// OWNED | one master owns the bus for its whole cyc, signals pass through
// GAP   | s_cyc held low for IDLE_GAP cycles between owners
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDLE_GAP    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   grant_valid
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [PW-1:0]          ptr, ptr_nxt;
  logic [PW-1:0]          owner, owner_nxt;
  logic [2:0]             gap_cnt, gap_cnt_nxt;
  logic [3:0]             outst, outst_nxt;

  logic [PW-1:0] win;
  logic          win_found;
  logic          own_cyc;
  logic          beat_accept;
  logic          ack_valid;

  // Scan from the master after the last owner, wrapping, so every requester is served in turn.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!win_found && bus.m_cyc[idx]) begin
        win       = PW'(idx);
        win_found = 1'b1;
      end
    end
  end

  assign own_cyc     = bus.m_cyc[owner];
  assign beat_accept = (state == OWNED) && bus.m_stb[owner] && !bus.s_stall;
  assign ack_valid   = (state == OWNED) && bus.s_ack && (outst != 4'd0);
  assign grant_valid = (state == OWNED);

  always_comb begin
    bus.s_cyc    = 1'b0;
    bus.s_stb    = 1'b0;
    bus.s_we     = 1'b0;
    bus.s_addr   = '0;
    bus.s_data_w = '0;
    bus.m_stall  = bus.m_cyc;
    bus.m_ack    = '0;
    bus.m_data_r = bus.s_data_r;
    if (state == OWNED) begin
      bus.s_cyc          = own_cyc;
      bus.s_stb          = bus.m_stb[owner];
      bus.s_we           = bus.m_we[owner];
      bus.s_addr         = bus.m_addr[32*owner +: 32];
      bus.s_data_w       = bus.m_data_w[32*owner +: 32];
      bus.m_stall[owner] = bus.s_stall;
      bus.m_ack[owner]   = ack_valid;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    gap_cnt_nxt = gap_cnt;
    outst_nxt   = outst;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = OWNED;
          grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
          owner_nxt = win;
          outst_nxt = 4'd0;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          // Dropping cyc abandons any acks still in flight.
          state_nxt   = GAP;
          grant_nxt   = '0;
          ptr_nxt     = owner;
          gap_cnt_nxt = 3'(IDLE_GAP - 1);
          outst_nxt   = 4'd0;
        end else if (beat_accept && !ack_valid) begin
          if (outst != 4'd15) outst_nxt = outst + 4'd1;
        end else if (!beat_accept && ack_valid) begin
          outst_nxt = outst - 4'd1;
        end
      end
      GAP: begin
        if (gap_cnt != 3'd0) begin
          gap_cnt_nxt = gap_cnt - 3'd1;
        end else if (win_found) begin
          state_nxt = OWNED;
          grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
          owner_nxt = win;
          outst_nxt = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= PW'(NUM_MASTERS - 1);
      owner   <= '0;
      gap_cnt <= 3'd0;
      outst   <= 4'd0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      gap_cnt <= gap_cnt_nxt;
      outst   <= outst_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a 2-master instance (gap 1) and a 4-master instance (gap 2).
module tb_wb_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] grant_a;
  logic       gv_a;
  logic [3:0] grant_b;
  logic       gv_b;

  wb_rr_arbiter_if #(.NUM_MASTERS(2)) ba ();
  wb_rr_arbiter_if #(.NUM_MASTERS(4)) bb ();

  wb_rr_arbiter #(.NUM_MASTERS(2), .IDLE_GAP(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ba.slave), .grant(grant_a), .grant_valid(gv_a)
  );
  wb_rr_arbiter #(.NUM_MASTERS(4), .IDLE_GAP(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bb.slave), .grant(grant_b), .grant_valid(gv_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ba.m_addr = '0; ba.m_data_w = '0; ba.m_we = '0; ba.m_stb = '0; ba.m_cyc = '0;
    ba.s_data_r = '0; ba.s_ack = 1'b0; ba.s_stall = 1'b0;
    bb.m_addr = '0; bb.m_data_w = '0; bb.m_we = '0; bb.m_stb = '0; bb.m_cyc = '0;
    bb.s_data_r = '0; bb.s_ack = 1'b0; bb.s_stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ba.m_cyc = 2'b10;
    settle();
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant_a); end
    total++; if (gv_a !== 1'b0) begin bad++; $display("FAIL reset_gv: got %b want 0", gv_a); end
    total++; if ({ba.s_cyc, ba.s_stb, ba.s_we} !== 3'b000) begin bad++; $display("FAIL reset_s_ctl: got %b want 000", {ba.s_cyc, ba.s_stb, ba.s_we}); end
    total++; if (ba.m_stall !== 2'b10) begin bad++; $display("FAIL reset_stall: got %b want 10", ba.m_stall); end
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", ba.m_ack); end
    ba.m_cyc = 2'b00;
    tick();
  endtask

  task automatic test_first_grant();
    do_reset();
    ba.m_cyc = 2'b01;
    ba.s_stall = 1'b1;
    ba.m_addr = {32'h0000_0200, 32'h0000_0100};
    ba.m_stb = 2'b10;
    settle();
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL first_c0_grant: got %b want 00", grant_a); end
    tick();
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL first_grant: got %b want 01", grant_a); end
    total++; if (gv_a !== 1'b1) begin bad++; $display("FAIL first_gv: got %b want 1", gv_a); end
    total++; if (ba.s_cyc !== 1'b1) begin bad++; $display("FAIL first_s_cyc: got %b want 1", ba.s_cyc); end
    total++; if (ba.m_stall !== 2'b01) begin bad++; $display("FAIL first_stall_hi: got %b want 01", ba.m_stall); end
    total++; if (ba.s_stb !== 1'b0) begin bad++; $display("FAIL first_nonowner_stb: got %b want 0", ba.s_stb); end
    total++; if (ba.s_addr !== 32'h0000_0100) begin bad++; $display("FAIL first_s_addr: got %h want 00000100", ba.s_addr); end
    ba.s_stall = 1'b0;
    settle();
    total++; if (ba.m_stall !== 2'b00) begin bad++; $display("FAIL first_stall_lo: got %b want 00", ba.m_stall); end
    ba.m_stb = 2'b00;
    ba.m_cyc = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_handover();
    do_reset();
    ba.m_cyc = 2'b11;
    tick();
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL ho_first: got %b want 01", grant_a); end
    ba.m_addr = {32'h0000_0990, 32'h0000_0004};
    ba.m_data_w = {32'h1111_2222, 32'hDEAD_BEEF};
    ba.m_we = 2'b11;
    ba.m_stb = 2'b11;
    settle();
    total++; if ({ba.s_stb, ba.s_we, ba.s_addr} !== {1'b1, 1'b1, 32'h0000_0004}) begin bad++; $display("FAIL ho_s_req: got %b%b %h want 11 00000004", ba.s_stb, ba.s_we, ba.s_addr); end
    total++; if (ba.s_data_w !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ho_s_data_w: got %h want deadbeef", ba.s_data_w); end
    total++; if (ba.m_stall !== 2'b10) begin bad++; $display("FAIL ho_stall: got %b want 10", ba.m_stall); end
    tick();
    ba.m_stb = 2'b00;
    ba.m_we = 2'b00;
    ba.s_ack = 1'b1;
    ba.s_data_r = 32'hCAFE_0042;
    settle();
    total++; if (ba.m_ack !== 2'b01) begin bad++; $display("FAIL ho_ack: got %b want 01", ba.m_ack); end
    total++; if (ba.m_data_r !== 32'hCAFE_0042) begin bad++; $display("FAIL ho_data_r: got %h want cafe0042", ba.m_data_r); end
    tick();
    ba.s_ack = 1'b0;
    ba.m_cyc = 2'b10;
    settle();
    total++; if (ba.s_cyc !== 1'b0) begin bad++; $display("FAIL ho_drop_s_cyc: got %b want 0", ba.s_cyc); end
    tick();
    total++; if ({grant_a, ba.s_cyc} !== 3'b000) begin bad++; $display("FAIL ho_gap: got grant=%b s_cyc=%b want 00 0", grant_a, ba.s_cyc); end
    total++; if (ba.m_stall !== 2'b10) begin bad++; $display("FAIL ho_gap_stall: got %b want 10", ba.m_stall); end
    tick();
    total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL ho_second: got %b want 10", grant_a); end
    total++; if (ba.s_addr !== 32'h0000_0990) begin bad++; $display("FAIL ho_second_addr: got %h want 00000990", ba.s_addr); end
    ba.m_cyc = 2'b01;
    tick();
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL ho_gap2: got %b want 00", grant_a); end
    tick();
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL ho_third: got %b want 01", grant_a); end
    ba.m_cyc = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_pipeline();
    do_reset();
    ba.m_cyc = 2'b11;
    tick();
    ba.m_stb = 2'b01;
    ba.s_ack = 1'b1;
    settle();
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL pipe_early_ack: got %b want 00", ba.m_ack); end
    tick();
    ba.s_ack = 1'b0;
    settle();
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL pipe_c1_ack: got %b want 00", ba.m_ack); end
    tick();
    ba.m_stb = 2'b00;
    ba.s_ack = 1'b1;
    settle();
    total++; if (ba.m_ack !== 2'b01) begin bad++; $display("FAIL pipe_ack1: got %b want 01", ba.m_ack); end
    tick();
    settle();
    total++; if (ba.m_ack !== 2'b01) begin bad++; $display("FAIL pipe_ack2: got %b want 01", ba.m_ack); end
    tick();
    ba.s_ack = 1'b0;
    settle();
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL pipe_after: got %b want 00", ba.m_ack); end
    tick();
    ba.s_ack = 1'b1;
    settle();
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL pipe_outst_zero: got %b want 00", ba.m_ack); end
    ba.s_ack = 1'b0;
    ba.m_cyc = 2'b00;
    tick();
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    ba.s_ack = 1'b1;
    settle();
    total++; if ({ba.m_ack, grant_a} !== 4'b0000) begin bad++; $display("FAIL spur_idle: got ack=%b grant=%b want 00 00", ba.m_ack, grant_a); end
    ba.m_cyc = 2'b01;
    tick();
    total++; if ({ba.m_ack, grant_a} !== 4'b0001) begin bad++; $display("FAIL spur_owned: got ack=%b grant=%b want 00 01", ba.m_ack, grant_a); end
    ba.m_cyc = 2'b00;
    tick();
    total++; if ({ba.m_ack, grant_a} !== 4'b0000) begin bad++; $display("FAIL spur_gap: got ack=%b grant=%b want 00 00", ba.m_ack, grant_a); end
    tick();
    total++; if ({ba.m_ack, grant_a, gv_a} !== 5'b00000) begin bad++; $display("FAIL spur_idle2: got ack=%b grant=%b gv=%b want 00 00 0", ba.m_ack, grant_a, gv_a); end
    ba.s_ack = 1'b0;
    tick();
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic test_rr4();
    do_reset();
    bb.m_addr = {32'h0000_1003, 32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
    bb.m_cyc = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (grant_b !== rr_exp[i]) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_b, rr_exp[i]); end
      total++; if (bb.s_addr !== 32'h0000_1000 + (i % 4)) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", i, bb.s_addr, 32'h0000_1000 + (i % 4)); end
      total++; if (bb.m_stall !== (4'hF & ~rr_exp[i])) begin bad++; $display("FAIL rr_stall[%0d]: got %b want %b", i, bb.m_stall, 4'hF & ~rr_exp[i]); end
      tick();
      tick();
      bb.m_cyc = 4'hF & ~rr_exp[i];
      tick();
      total++; if ({grant_b, gv_b, bb.s_cyc} !== 6'b000000) begin bad++; $display("FAIL rr_gap1[%0d]: got grant=%b gv=%b s_cyc=%b want 0000 0 0", i, grant_b, gv_b, bb.s_cyc); end
      bb.m_cyc = 4'hF;
      tick();
      total++; if ({grant_b, bb.s_cyc} !== 5'b00000) begin bad++; $display("FAIL rr_gap2[%0d]: got grant=%b s_cyc=%b want 0000 0", i, grant_b, bb.s_cyc); end
      tick();
    end
    bb.m_cyc = 4'h0;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    ba.m_cyc = 2'b11;
    tick();
    ba.m_cyc = 2'b10;
    tick();
    tick();
    total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL mr_owner1: got %b want 10", grant_a); end
    ba.m_cyc = 2'b11;
    ba.m_stb = 2'b10;
    tick();
    ba.m_stb = 2'b00;
    rst = 1'b1;
    settle();
    total++; if ({grant_a, ba.s_cyc} !== 3'b101) begin bad++; $display("FAIL mr_before_edge: got grant=%b s_cyc=%b want 10 1", grant_a, ba.s_cyc); end
    tick();
    rst = 1'b0;
    ba.s_ack = 1'b1;
    settle();
    total++; if ({grant_a, gv_a, ba.s_cyc} !== 4'b0000) begin bad++; $display("FAIL mr_after_edge: got grant=%b gv=%b s_cyc=%b want 00 0 0", grant_a, gv_a, ba.s_cyc); end
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL mr_ack_idle: got %b want 00", ba.m_ack); end
    tick();
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL mr_ptr_reset: got %b want 01", grant_a); end
    total++; if (ba.m_ack !== 2'b00) begin bad++; $display("FAIL mr_ack_stale: got %b want 00", ba.m_ack); end
    ba.s_ack = 1'b0;
    ba.m_cyc = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_first_grant();
    test_handover();
    test_pipeline();
    test_spurious();
    test_rr4();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
